// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - MULDIV_OP_* : RV32M funct3 encodings
//   - MD_*        : muldiv_unit FSM state encoding
//   - XLEN_DEFAULT: default operand/result width
//   - helpers that classify an op as divide and report which operands are signed
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MULDIV_OP_MUL    = 3'd0,
    MULDIV_OP_MULH   = 3'd1,
    MULDIV_OP_MULHSU = 3'd2,
    MULDIV_OP_MULHU  = 3'd3,
    MULDIV_OP_DIV    = 3'd4,
    MULDIV_OP_DIVU   = 3'd5,
    MULDIV_OP_REM    = 3'd6,
    MULDIV_OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(muldiv_op_e op);
    logic [2:0] raw;
    raw = op;
    return raw[2];
  endfunction

  function automatic logic op_rs1_signed(muldiv_op_e op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
  endfunction

  function automatic logic op_rs2_signed(muldiv_op_e op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step on unsigned values.
//   rem_in  : partial remainder before the step (always < divisor)
//   din     : next dividend bit shifted into the remainder
//   divisor : unsigned divisor
//   rem_out : partial remainder after the step
//   q_bit   : quotient bit produced by the step
module muldiv_div_step
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            din,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  assign shifted = {rem_in, din};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtract happens the true difference is < divisor, so it fits
  // in XLEN bits and the modulo subtraction below is exact.
  assign rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
//   clk, rst           : clock, asynchronous active-low reset
//   start, op          : request and funct3 op, sampled only in IDLE
//   rs1_data, rs2_data : operands, latched at start
//   rd_addr            : destination register, latched at start
//   flush              : abort the in-flight operation / kill the strobe
//   busy               : unit occupied (RUN or DONE)
//   done               : one-cycle result strobe
//   wb_we, wb_rd, wb_data : register-file write port
// Build option MULDIV_FAST_MUL_EN: multiplies use a combinational 2*XLEN
// multiplier and complete with fast-path latency; divides are unchanged.
//
// state   | meaning
// MD_IDLE | waiting for start
// MD_RUN  | one radix-2 step per cycle, then one finalize cycle
// MD_DONE | result strobe cycle
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_e         state, state_next;
  logic              load, step, finish;

  muldiv_op_e        op_q;
  logic [CW-1:0]     cnt;
  // Shared work register: multiply = {product_hi, multiplier/product_lo},
  // divide = {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   rs1_q;
  logic              neg_q, neg_r, dz_q, fast_q;

  // Start-time decode
  muldiv_op_e      op_in;
  logic            s1, s2, dz_in, ovf_in, fast_in;
  logic [XLEN-1:0] rs1_mag, rs2_mag;

  assign op_in  = muldiv_op_e'(op);
  assign s1     = op_rs1_signed(op_in) & rs1_data[XLEN-1];
  assign s2     = op_rs2_signed(op_in) & rs2_data[XLEN-1];
  assign dz_in  = op_is_div(op_in) && (rs2_data == '0);
  assign ovf_in = ((op_in == MULDIV_OP_DIV) || (op_in == MULDIV_OP_REM)) &&
                  (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
`ifdef MULDIV_FAST_MUL_EN
  assign fast_in = dz_in | ovf_in | ~op_is_div(op_in);
`else
  assign fast_in = dz_in | ovf_in;
`endif
  // Both multiply and divide iterate on magnitudes; signs are re-applied at finalize.
  assign rs1_mag = s1 ? -rs1_data : rs1_data;
  assign rs2_mag = s2 ? -rs2_data : rs2_data;

  // Iteration datapath
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] div_next, mul_next;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc[2*XLEN-1:XLEN]),
    .din     (acc[XLEN-1]),
    .divisor (opnd),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  assign div_next = {div_rem, acc[XLEN-2:0], div_q};
  assign mul_add  = acc[0] ? opnd : '0;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Finalize: sign fix-up and result select
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, remv, result;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = fast_q ? ({{XLEN{1'b0}}, acc[XLEN-1:0]} * {{XLEN{1'b0}}, opnd}) : acc;
`else
    prod_mag = acc;
`endif
    prod = neg_q ? -prod_mag : prod_mag;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remv = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = '0;
    case (op_q)
      MULDIV_OP_MUL:    result = prod[XLEN-1:0];
      MULDIV_OP_MULH,
      MULDIV_OP_MULHSU,
      MULDIV_OP_MULHU:  result = prod[2*XLEN-1:XLEN];
      MULDIV_OP_DIV,
      MULDIV_OP_DIVU:   result = fast_q ? (dz_q ? '1 : rs1_q) : quo;
      MULDIV_OP_REM,
      MULDIV_OP_REMU:   result = fast_q ? (dz_q ? rs1_q : '0) : remv;
      default:          result = '0;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          state_next = MD_RUN;
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_next = MD_IDLE;
        end else if (fast_q || (cnt == CW'(XLEN))) begin
          // Fast paths skip iteration and spend only this finalize cycle in RUN.
          finish     = 1'b1;
          state_next = MD_DONE;
        end else begin
          step = 1'b1;
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= MULDIV_OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      rs1_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      fast_q  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (load) begin
        op_q   <= op_in;
        cnt    <= '0;
        acc    <= {{XLEN{1'b0}}, rs1_mag};
        opnd   <= rs2_mag;
        rs1_q  <= rs1_data;
        neg_q  <= s1 ^ s2;
        neg_r  <= s1;
        dz_q   <= dz_in;
        fast_q <= fast_in;
        wb_rd  <= rd_addr;
      end
      if (step) begin
        cnt <= cnt + 1'b1;
        acc <= op_is_div(op_q) ? div_next : mul_next;
      end
      if (finish) wb_data <= result;
    end
  end

  // A flush in the DONE cycle kills the strobe combinationally.
  assign busy  = (state != MD_IDLE);
  assign done  = (state == MD_DONE) && !flush;
  assign wb_we = done && (wb_rd != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        busy, done, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Counts edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    if (!done) n = -1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic [4:0] rdo, output logic we, output int lat);
    repeat (2) @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_data = 32'h5A5A_A5A5;
    rs2_data = 32'h1234_5678;
    rd_addr  = 5'd31;
    wait_done(lat);
    data = wb_data; rdo = wb_rd; we = wb_we;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    logic [31:0] d; logic [4:0] r; logic w; int l;
    for (int i = 0; i < v.size(); i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), d, r, w, l);
      checks++; if (l != v[i].lat) begin failures++; $display("FAIL %s[%0d]_lat got=%0d exp=%0d", name, i, l, v[i].lat); end
      checks++; if (d !== v[i].exp) begin failures++; $display("FAIL %s[%0d]_data got=%h exp=%h", name, i, d, v[i].exp); end
      checks++; if (r !== 5'(i + 1)) begin failures++; $display("FAIL %s[%0d]_rd got=%0d exp=%0d", name, i, r, i + 1); end
      checks++; if (w !== 1'b1) begin failures++; $display("FAIL %s[%0d]_we got=%b exp=1", name, i, w); end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{3'd0, 32'd6,          32'd10,         32'h0000_003C, MUL_LAT});
    v.push_back('{3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, MUL_LAT});
    v.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, MUL_LAT});
    v.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, MUL_LAT});
    v.push_back('{3'd2, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF, MUL_LAT});
    v.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, MUL_LAT});
    v.push_back('{3'd1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF, MUL_LAT});
    test_vectors("mul", v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, DIV_LAT});
    v.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, DIV_LAT});
    v.push_back('{3'd4, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA, DIV_LAT});
    v.push_back('{3'd6, 32'd20,         32'hFFFF_FFFD,  32'h0000_0002, DIV_LAT});
    v.push_back('{3'd5, 32'd100,        32'd7,          32'h0000_000E, DIV_LAT});
    v.push_back('{3'd7, 32'd100,        32'd7,          32'h0000_0002, DIV_LAT});
    v.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, DIV_LAT});
    v.push_back('{3'd7, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, DIV_LAT});
    v.push_back('{3'd5, 32'd9,          32'd0,          32'hFFFF_FFFF, FAST_LAT});
    v.push_back('{3'd7, 32'd9,          32'd0,          32'h0000_0009, FAST_LAT});
    v.push_back('{3'd4, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF, FAST_LAT});
    v.push_back('{3'd6, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB, FAST_LAT});
    v.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, FAST_LAT});
    v.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, FAST_LAT});
    test_vectors("div", v);
  endtask

  task automatic test_flush_run();
    int seen = 0;
    repeat (2) @(negedge clk);
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_run_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_run_done got=%b exp=0", done); end
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_run_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_flush_done();
    repeat (2) @(negedge clk);
    op = 3'd5; rs1_data = 32'd9; rs2_data = 32'd0; rd_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL flush_done_pre got=%b exp=1", done); end
    flush = 1'b1; #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done_done got=%b exp=0", done); end
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL flush_done_we got=%b exp=0", wb_we); end
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_flush_start();
    int seen = 0;
    repeat (2) @(negedge clk);
    op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3; rd_addr = 5'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_start_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_ignore_start();
    int n; int seen = 0;
    repeat (2) @(negedge clk);
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd3; rd_addr = 5'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    checks++; if (n != 27) begin failures++; $display("FAIL ignore_start_lat got=%0d exp=27", n); end
    checks++; if (wb_data !== 32'h0000_000E) begin failures++; $display("FAIL ignore_start_data got=%h exp=0000000e", wb_data); end
    checks++; if (wb_rd !== 5'd4) begin failures++; $display("FAIL ignore_start_rd got=%0d exp=4", wb_rd); end
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL ignore_start_no_queue got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [4:0] r; logic w; int l;
    repeat (2) @(negedge clk);
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL rst_mid_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", wb_data); end
    @(negedge clk); rst = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 5'd9, d, r, w, l);
    checks++; if (d !== 32'h0000_000E) begin failures++; $display("FAIL rst_recover_data got=%h exp=0000000e", d); end
    checks++; if (l != DIV_LAT) begin failures++; $display("FAIL rst_recover_lat got=%0d exp=%0d", l, DIV_LAT); end
  endtask

  task automatic test_rd_zero();
    logic [31:0] d; logic [4:0] r; logic w; int l;
    run_op(3'd0, 32'd3, 32'd4, 5'd0, d, r, w, l);
    checks++; if (l != MUL_LAT) begin failures++; $display("FAIL rd0_lat got=%0d exp=%0d", l, MUL_LAT); end
    checks++; if (d !== 32'h0000_000C) begin failures++; $display("FAIL rd0_data got=%h exp=0000000c", d); end
    checks++; if (w !== 1'b0) begin failures++; $display("FAIL rd0_we got=%b exp=0", w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [4:0] r; logic w; int l; int n;
    run_op(3'd5, 32'd9, 32'd0, 5'd2, d, r, w, l);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_first_data got=%h exp=ffffffff", d); end
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd6; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_ignore got=%b exp=0", busy); end
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n != DIV_LAT) begin failures++; $display("FAIL b2b_lat got=%0d exp=%0d", n, DIV_LAT); end
    checks++; if (wb_data !== 32'h0000_000E) begin failures++; $display("FAIL b2b_data got=%h exp=0000000e", wb_data); end
    checks++; if (wb_rd !== 5'd6) begin failures++; $display("FAIL b2b_rd got=%0d exp=6", wb_rd); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_strobe_len got=%b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush_run();
    test_flush_done();
    test_flush_start();
    test_ignore_start();
    test_reset_mid();
    test_rd_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
